nes_button_debouncer: RTL and testbench
=======================================

NES_BUTTON_DEBOUNCER -- requirements
Module: nes_button_debouncer

Interface
REQ-001 Parameter NUM_BUTTONS, default 8, number of independent button channels (1..8).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a new level (>=1).
REQ-003 Parameter ACTIVE_LOW, default 1, raw input polarity: 1 means pressed = 0.
REQ-004 pixelClock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 vSyncStart  input  1  one-cycle frame strobe, synchronous to pixelClock.
REQ-007 buttonsRaw  input  NUM_BUTTONS  asynchronous raw switch inputs, polarity per ACTIVE_LOW.
REQ-008 buttonsLevel  output  NUM_BUTTONS  debounced state, active-high (1 = pressed).
REQ-009 buttonsPressed  output  NUM_BUTTONS  one-cycle pulse per channel on each debounced 0->1 transition.
REQ-010 buttons  output  8  frame-latched button byte, active-high; bits >= NUM_BUTTONS are always 0.

Function
REQ-011 Each raw bit passes through a 2-flop synchronizer and is then normalised to active-high.
REQ-012 Each channel has its own debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-013 Synchronized value equal to buttonsLevel bit: counter cleared to 0.
REQ-014 Synchronized value differs: counter increments; when counter == DEBOUNCE_CYCLES-1, the buttonsLevel bit flips on that edge and the counter clears.
REQ-015 Latency: a clean step held stable changes buttonsLevel exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples the new raw value.
REQ-016 A bounce (return to the accepted level) before the threshold clears the counter; no output change.
REQ-017 The counter never wraps; it saturates by construction because it clears at threshold.
REQ-018 buttonsPressed bit is 1 for exactly the cycle after buttonsLevel goes 0->1; no pulse on 1->0.
REQ-019 On a vSyncStart cycle, buttons <= zero-extended (buttonsLevel | capture), where capture is defined in REQ-026; otherwise buttons holds.
REQ-020 buttons changes only on edges where vSyncStart = 1; zero latency from vSyncStart to register update.
REQ-021 Channels are fully independent; simultaneous transitions on any number of channels are all processed in the same cycle.
REQ-022 vSyncStart held high for multiple cycles re-latches every cycle (no edge detection).

Reset
REQ-023 While reset is high: synchronizer flops hold the released value (1 if ACTIVE_LOW, else 0), counters 0, buttonsLevel 0, buttonsPressed 0, buttons 0, capture 0.
REQ-024 Reset asserted mid-debounce discards the partial count; after release, a held button is accepted only after the full 2+DEBOUNCE_CYCLES latency.
REQ-025 No buttonsPressed pulse is generated by reset deassertion alone.

Configuration
REQ-026 Macro NES_BUTTON_STICKY_EN defined: a per-channel capture register sets on buttonsPressed, clears on vSyncStart, and is ORed into buttons at latch so taps shorter than one frame are reported; a press arriving on the same edge as vSyncStart is included in that latch and not retained.
REQ-027 Macro NES_BUTTON_STICKY_EN undefined: capture is constant 0, so buttons = buttonsLevel sampled at vSyncStart; no capture registers are synthesised.

Verification (DEBOUNCE_CYCLES=4, NUM_BUTTONS=8, ACTIVE_LOW=1)
REQ-028 Reset, then buttonsRaw=8'hFE held -> buttonsLevel=8'h01 exactly 6 edges later; buttonsPressed=8'h01 for one cycle, one cycle after that.
REQ-029 buttonsRaw bit0 toggles 0/1 every 2 cycles for 40 cycles -> buttonsLevel stays 8'h00, no buttonsPressed pulse.
REQ-030 bit3 pressed and held, vSyncStart pulse 10 cycles later -> buttons=8'h08 on the following cycle and held until the next vSyncStart.
REQ-031 STICKY_EN: bit5 pressed 8 cycles then released, vSyncStart after release -> buttons=8'h20; next vSyncStart -> buttons=8'h00. Without macro -> buttons=8'h00 both times.
REQ-032 bit2 held 3 cycles into debounce, reset pulsed, bit2 still held -> buttonsLevel 0 until 6 edges after reset release, then 8'h04.
REQ-033 buttonsRaw=8'h00 (all pressed) -> all 8 buttonsLevel bits rise on the same edge; buttonsPressed=8'hFF for one cycle.

Source files
------------

// File: rtl/nes_button_debouncer_if.sv
// Button bus between the pad front end and its consumer.
// vSyncStart is a plain one-cycle strobe (no valid/ready): the consumer latches on every cycle it is high.
interface nes_button_debouncer_if #(
  parameter int NUM_BUTTONS = 8
);
  logic                   vSyncStart;
  logic [NUM_BUTTONS-1:0] buttonsRaw;
  logic [NUM_BUTTONS-1:0] buttonsLevel;
  logic [NUM_BUTTONS-1:0] buttonsPressed;
  logic [7:0]             buttons;

  modport master (
    output vSyncStart,
    output buttonsRaw,
    input  buttonsLevel,
    input  buttonsPressed,
    input  buttons
  );

  modport slave (
    input  vSyncStart,
    input  buttonsRaw,
    output buttonsLevel,
    output buttonsPressed,
    output buttons
  );
endinterface

// File: rtl/nes_button_debouncer.sv
// Per-channel synchroniser + debounce counter, rising-edge pulse and frame-latched button byte.
// Define NES_BUTTON_STICKY_EN to hold short taps until the next vSyncStart latch.
module nes_button_debouncer #(
  parameter int NUM_BUTTONS     = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input logic                  pixelClock,
  input logic                  reset,
  nes_button_debouncer_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] THRESH = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_BUTTONS-1:0] RELEASED = {NUM_BUTTONS{ACTIVE_LOW != 0}};

  logic [NUM_BUTTONS-1:0] sync1, sync2, sync_norm;
  logic [NUM_BUTTONS-1:0] level_q, level_prev, level_next;
  logic [NUM_BUTTONS-1:0] pressed_q;
  logic [NUM_BUTTONS-1:0] capture;
  logic [CW-1:0]          cnt_q    [NUM_BUTTONS];
  logic [CW-1:0]          cnt_next [NUM_BUTTONS];
  logic [7:0]             buttons_q;

  assign sync_norm = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // A channel only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_next = level_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_next[i] = '0;
      if (sync_norm[i] != level_q[i]) begin
        if (cnt_q[i] == THRESH) begin
          level_next[i] = ~level_q[i];
        end else begin
          cnt_next[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      sync1      <= RELEASED;
      sync2      <= RELEASED;
      level_q    <= '0;
      level_prev <= '0;
      pressed_q  <= '0;
      buttons_q  <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      sync1      <= bus.buttonsRaw;
      sync2      <= sync1;
      level_q    <= level_next;
      level_prev <= level_q;
      pressed_q  <= level_q & ~level_prev;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_next[i];
      if (bus.vSyncStart) buttons_q <= 8'(level_q | capture);
    end
  end

`ifdef NES_BUTTON_STICKY_EN
  logic [NUM_BUTTONS-1:0] capture_q;

  // A latch consumes the capture; a press landing on the latch edge is not kept.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      capture_q <= '0;
    end else if (bus.vSyncStart) begin
      capture_q <= '0;
    end else begin
      capture_q <= capture_q | pressed_q;
    end
  end

  assign capture = capture_q;
`else
  assign capture = '0;
`endif

  assign bus.buttonsLevel   = level_q;
  assign bus.buttonsPressed = pressed_q;
  assign bus.buttons        = buttons_q;
endmodule

// File: tb/tb_nes_button_debouncer.sv
// Directed + random bench for nes_button_debouncer (DEBOUNCE_CYCLES=4, 8 channels, active-low).
// The reference model keeps a history of raw samples and flips a channel when the last D usable samples all disagree.
module tb_nes_button_debouncer;
  localparam int N  = 8;
  localparam int D  = 4;
  localparam int AL = 1;

  logic pixelClock = 1'b0;
  logic reset      = 1'b1;

  always #5 pixelClock = ~pixelClock;

  nes_button_debouncer_if #(.NUM_BUTTONS(N)) bus ();

  nes_button_debouncer #(
    .NUM_BUTTONS(N),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(AL)
  ) dut (
    .pixelClock(pixelClock),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N-1:0] hist[$];
  logic [7:0]   exp_q[$];
  logic [N-1:0] m_level, m_level_old, m_pressed, m_cap;
  logic [7:0]   m_buttons;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    repeat (D + 2) hist.push_back('0);
    m_level     = '0;
    m_level_old = '0;
    m_pressed   = '0;
    m_cap       = '0;
    m_buttons   = '0;
  endtask

  // Raw sampled at edge k reaches the debounce decision at edge k+2.
  task automatic model_edge(input logic [N-1:0] raw, input logic vs);
    logic [N-1:0] nxt;
    logic         all_diff;
    int           n;
    hist.push_back((AL != 0) ? ~raw : raw);
    while (hist.size() > D + 3) void'(hist.pop_front());
    n   = hist.size();
    nxt = m_level;
    for (int c = 0; c < N; c++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) begin
        if (hist[n-3-j][c] == m_level[c]) all_diff = 1'b0;
      end
      if (all_diff) nxt[c] = ~m_level[c];
    end
    if (vs) exp_q.push_back(8'(m_level | m_cap));
`ifdef NES_BUTTON_STICKY_EN
    m_cap = vs ? '0 : (m_cap | m_pressed);
`endif
    m_pressed   = m_level & ~m_level_old;
    m_level_old = m_level;
    m_level     = nxt;
    if (exp_q.size() > 0) m_buttons = exp_q.pop_front();
  endtask

  task automatic step(input logic [N-1:0] raw, input logic vs);
    bus.buttonsRaw = raw;
    bus.vSyncStart = vs;
    @(posedge pixelClock);
    model_edge(raw, vs);
    #1;
    check("model_level", 8'(bus.buttonsLevel), 8'(m_level));
    check("model_pressed", 8'(bus.buttonsPressed), 8'(m_pressed));
    check("model_buttons", bus.buttons, m_buttons);
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    repeat (cycles) @(posedge pixelClock);
    #1;
    check("rst_level", 8'(bus.buttonsLevel), 8'h00);
    check("rst_pressed", 8'(bus.buttonsPressed), 8'h00);
    check("rst_buttons", bus.buttons, 8'h00);
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rnd_raw;
    logic         rnd_vs;
    int           vs_run;
    logic [7:0]   sticky_exp;

    bus.buttonsRaw = 8'hFF;
    bus.vSyncStart = 1'b0;
    pulse_reset(3);
    repeat (3) step(8'hFF, 1'b0);

    // Clean press on bit0: level at edge 6, pulse at edge 7
    for (int k = 1; k <= 8; k++) begin
      step(8'hFE, 1'b0);
      check("press_level", 8'(bus.buttonsLevel), (k >= 6) ? 8'h01 : 8'h00);
      check("press_pulse", 8'(bus.buttonsPressed), (k == 7) ? 8'h01 : 8'h00);
    end
    repeat (8) step(8'hFF, 1'b0);
    check("release_level", 8'(bus.buttonsLevel), 8'h00);

    // Bounce every 2 cycles never reaches the threshold
    for (int k = 0; k < 40; k++) begin
      step(((k / 2) % 2 == 1) ? 8'hFF : 8'hFE, 1'b0);
      check("bounce_level", 8'(bus.buttonsLevel), 8'h00);
      check("bounce_pulse", 8'(bus.buttonsPressed), 8'h00);
    end
    repeat (4) step(8'hFF, 1'b0);

    // Held bit3 latched by vSyncStart and held until the next one
    repeat (10) step(8'hF7, 1'b0);
    check("hold_level", 8'(bus.buttonsLevel), 8'h08);
    step(8'hF7, 1'b1);
    check("latch_buttons", bus.buttons, 8'h08);
    repeat (5) step(8'hF7, 1'b0);
    check("latch_hold", bus.buttons, 8'h08);
    repeat (8) step(8'hFF, 1'b0);
    check("latch_hold_released", bus.buttons, 8'h08);
    check("latch_level_released", 8'(bus.buttonsLevel), 8'h00);
    step(8'hFF, 1'b1);
    check("latch_cleared", bus.buttons, 8'h00);

    // Short tap on bit5 released before the frame latch
    repeat (8) step(8'hDF, 1'b0);
    repeat (8) step(8'hFF, 1'b0);
    check("tap_level", 8'(bus.buttonsLevel), 8'h00);
`ifdef NES_BUTTON_STICKY_EN
    sticky_exp = 8'h20;
`else
    sticky_exp = 8'h00;
`endif
    step(8'hFF, 1'b1);
    check("tap_first_latch", bus.buttons, sticky_exp);
    repeat (2) step(8'hFF, 1'b0);
    step(8'hFF, 1'b1);
    check("tap_second_latch", bus.buttons, 8'h00);

    // Reset mid-debounce discards the partial count
    repeat (3) step(8'hFB, 1'b0);
    pulse_reset(2);
    for (int k = 1; k <= 8; k++) begin
      step(8'hFB, 1'b0);
      check("rst_mid_level", 8'(bus.buttonsLevel), (k >= 6) ? 8'h04 : 8'h00);
      check("rst_mid_pulse", 8'(bus.buttonsPressed), (k == 7) ? 8'h04 : 8'h00);
    end
    repeat (8) step(8'hFF, 1'b0);

    // All channels pressed together
    for (int k = 1; k <= 8; k++) begin
      step(8'h00, 1'b0);
      check("all_level", 8'(bus.buttonsLevel), (k >= 6) ? 8'hFF : 8'h00);
      check("all_pulse", 8'(bus.buttonsPressed), (k == 7) ? 8'hFF : 8'h00);
    end
    step(8'h00, 1'b1);
    check("all_latch", bus.buttons, 8'hFF);
    repeat (8) step(8'hFF, 1'b0);

    // Random raw activity with occasional multi-cycle vSyncStart and a mid-run reset
    rnd_raw = 8'hFF;
    vs_run  = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) rnd_raw = 8'($urandom);
      if ($urandom_range(0, 9) == 0) rnd_raw[$urandom_range(0, N-1)] ^= 1'b1;
      if (vs_run == 0 && $urandom_range(0, 11) == 0) vs_run = $urandom_range(1, 3);
      rnd_vs = (vs_run > 0);
      if (vs_run > 0) vs_run--;
      step(rnd_raw, rnd_vs);
      if (k == 300) pulse_reset(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
